// File: rtl/mfp_switch_button_debouncer.sv
// Input conditioner for board slide switches and pushbuttons.
// Each raw pin is synchronised into HCLK and debounced against a shared
// prescaled tick. Buttons also get a one-cycle press pulse on 0->1.

// One lane: two-flop synchroniser followed by a tick-counted debouncer.
module mfp_debounce_lane #(
  parameter int STABLE_TICKS = 4
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic tick,
  input  logic raw,
  output logic level
);
  localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STABLE_TICKS - 1);

  logic          s1, s2;
  logic [SW-1:0] scnt;

  // Plain two-flop synchroniser, nothing between the stages.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it survives STABLE_TICKS ticks in a row;
  // any sample back at the held level throws the progress away.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      scnt  <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      scnt <= '0;
    end else if (tick) begin
      if (scnt == SMAX) begin
        level <= s2;
        scnt  <= '0;
      end else begin
        scnt <= scnt + SW'(1);
      end
    end
  end
endmodule

module mfp_switch_button_debouncer #(
  parameter int N_SWITCHES   = 18,
  parameter int N_BUTTONS    = 5,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [N_SWITCHES-1:0] raw_switches,
  input  logic [N_BUTTONS-1:0]  raw_buttons,
  output logic [N_SWITCHES-1:0] IO_Switches,
  output logic [N_BUTTONS-1:0]  IO_Buttons,
  output logic [N_BUTTONS-1:0]  IO_ButtonPress
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]        pcnt;
  logic                 tick;
  logic [N_BUTTONS-1:0] bdly;

  // Free-running prescaler, wraps at TICK_DIV-1; the tick is shared by all lanes.
  always_ff @(posedge HCLK) begin
    if (HRESET)           pcnt <= '0;
    else if (pcnt == PMAX) pcnt <= '0;
    else                  pcnt <= pcnt + PW'(1);
  end

  assign tick = (pcnt == PMAX);

  genvar i;
  generate
    for (i = 0; i < N_SWITCHES; i++) begin : g_sw
      mfp_debounce_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .tick   (tick),
        .raw    (raw_switches[i]),
        .level  (IO_Switches[i])
      );
    end
    for (i = 0; i < N_BUTTONS; i++) begin : g_btn
      mfp_debounce_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .tick   (tick),
        .raw    (raw_buttons[i]),
        .level  (IO_Buttons[i])
      );
    end
  endgenerate

  // Previous debounced button level, for rising-edge detection.
  always_ff @(posedge HCLK) begin
    if (HRESET) bdly <= '0;
    else        bdly <= IO_Buttons;
  end

  // Press pulse is high in the first cycle a button reads 1, never on release.
  assign IO_ButtonPress = IO_Buttons & ~bdly;
endmodule

// File: doc/mfp_switch_button_debouncer.md
# mfp_switch_button_debouncer

Input conditioner between the board's raw slide switches and pushbuttons and the GPIO AHB-Lite slave's `IO_Switches` / `IO_Buttons` inputs. Each raw pin is synchronised into the `HCLK` domain and debounced against a shared prescaled tick. The GPIO slave therefore only ever samples clean, glitch-free levels. A one-cycle press pulse per button is also provided for interrupt or counter logic.

## Interface
- `N_SWITCHES`, 18: number of slide-switch inputs.
- `N_BUTTONS`, 5: number of pushbutton inputs.
- `TICK_DIV`, 50000: `HCLK` cycles per debounce tick; legal range ≥1; 1 = tick every cycle.
- `STABLE_TICKS`, 4: consecutive ticks a new level must persist before it is accepted; legal range ≥1.

- `HCLK`  in  1: the single clock. One clock; reset is synchronous and active-high.
- `HRESET`  in  1: synchronous, active-high reset.
- `raw_switches`  in  N_SWITCHES: asynchronous board switch pins.
- `raw_buttons`  in  N_BUTTONS: asynchronous board button pins, active-high pressed.
- `IO_Switches`  out  N_SWITCHES: debounced switch levels, registered; drives GPIO slave.
- `IO_Buttons`  out  N_BUTTONS: debounced button levels, registered; drives GPIO slave.
- `IO_ButtonPress`  out  N_BUTTONS: one-`HCLK` pulse on each debounced 0→1 button transition.

## Operation
- Synchroniser: per bit, two flops `s1 <= raw`, `s2 <= s1`. No logic between the stages.
- Prescaler: counter `pcnt`, width clog2(TICK_DIV) (min 1).
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` = (`pcnt` == TICK_DIV-1), combinational. Free-running and shared by all bits.
- Per-bit debounce (switches and buttons identical, bit `i`), counter `scnt[i]`, width clog2(STABLE_TICKS) (min 1):
  - `s2[i]` == `out[i]`: `scnt[i] <= 0`. Any glitch back to the held level discards progress.
  - `s2[i]` != `out[i]` and `tick` and `scnt[i]` == STABLE_TICKS-1: `out[i] <= s2[i]`, `scnt[i] <= 0`.
  - `s2[i]` != `out[i]` and `tick` otherwise: `scnt[i] <= scnt[i]+1`.
  - `s2[i]` != `out[i]`, no `tick`: hold.
- Press detect: `bdly <= IO_Buttons` each cycle; `IO_ButtonPress = IO_Buttons & ~bdly`.
  - Exactly one cycle high per accepted press.
  - No pulse on release.
- Bits are fully independent. Simultaneous changes on several bits are each accepted on their own schedule.
- `scnt` never exceeds STABLE_TICKS-1 and does not wrap.

## Timing
- Reset, evaluated at an `HCLK` edge with `HRESET`=1, clears to 0: `s1`, `s2`, `pcnt`, all `scnt`, `IO_Switches`, `IO_Buttons`, `bdly`.
  - `IO_ButtonPress` is therefore 0 during and the cycle after reset.
  - Reset mid-debounce discards all progress.
  - A pin held high through reset is accepted as a fresh 0→1 transition after release of reset. For buttons this produces one press pulse.
- Latency, TICK_DIV=1: a raw level change stable before edge E appears on the output after edge E+STABLE_TICKS+1, i.e. STABLE_TICKS+2 edges.
- Latency, general: between (STABLE_TICKS-1)·TICK_DIV+3 and STABLE_TICKS·TICK_DIV+2 edges, depending on prescaler phase.
- Rejection: any raw pulse shorter than (STABLE_TICKS-1)·TICK_DIV+1 cycles never reaches the output.
- `IO_ButtonPress` is asserted in the same cycle `IO_Buttons` first reads 1.
- No combinational path from `raw_*` to any output.

## Test plan
- Reset: drive all raw pins 1, assert `HRESET` 3 cycles.
  - During reset all outputs read 0.
  - With TICK_DIV=1, STABLE_TICKS=3, after release `IO_Switches`=all-ones and `IO_Buttons`=5'h1F exactly 5 edges later.
  - One `IO_ButtonPress`=5'h1F pulse.
- Clean press, TICK_DIV=1, STABLE_TICKS=3: raw_buttons[0] 0→1 before edge 1.
  - `IO_Buttons[0]`=1 after edge 5.
  - `IO_ButtonPress[0]`=1 for exactly that one cycle.
  - Release gives `IO_Buttons[0]`=0 5 edges later with no pulse.
- Glitch reject, TICK_DIV=4, STABLE_TICKS=3: toggle raw_switches[7] high for 8 cycles, then low.
  - `IO_Switches[7]` stays 0 throughout.
  - Holding it high ≥14 cycles sets it to 1.
- Bounce, TICK_DIV=4, STABLE_TICKS=3: raw_buttons[2] toggles every 3 cycles for 40 cycles, then holds 1.
  - Exactly one `IO_ButtonPress[2]` pulse, within 14 cycles of the final hold.
- Reset mid-debounce, TICK_DIV=4, STABLE_TICKS=3: raw_switches[0]=1 for 9 cycles, assert `HRESET` one cycle, keep pin high.
  - `IO_Switches[0]` stays 0 for at least 11 cycles after reset, then becomes 1.
- Independence: change switches[3] and buttons[4] on the same edge with TICK_DIV=1, STABLE_TICKS=2.
  - Both outputs update on the same edge, 4 edges later.
  - All other bits remain unchanged.
